// File: rtl/spi_rr_arbiter_pkg.sv
// Shared definitions for the SPI round-robin arbiter: FSM state encoding and
// default widths that match the SPI master's data word and chip-select count.
package spi_rr_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_XFER,
        ST_DONE,
        ST_ERR,
        ST_GAP
    } arb_state_e;

    localparam int unsigned SPI_DW_DEF   = 12;
    localparam int unsigned SPI_NSLV_DEF = 4;

endpackage

// File: rtl/spi_rr_arbiter_pick.sv
// Rotating-priority encoder: the first set request at or after ptr wins,
// wrapping from NREQ-1 back to 0.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] win,
    output logic [IW-1:0]   win_idx,
    output logic            any
);

    int unsigned idx;
    logic [IW-1:0] sel;
    logic found;

    always_comb begin
        win     = '0;
        win_idx = '0;
        found   = 1'b0;
        idx     = 0;
        sel     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            sel = IW'(idx);
            if (!found && req[sel]) begin
                found    = 1'b1;
                win[sel] = 1'b1;
                win_idx  = sel;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/spi_rr_arbiter.sv
// Shares one SPI master among NREQ requesters with round-robin arbitration,
// slave-select validation and a done-timeout watchdog. All outputs registered.
module spi_rr_arbiter
    import spi_rr_arbiter_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned DW      = SPI_DW_DEF,
    parameter int unsigned NSLV    = SPI_NSLV_DEF,
    parameter int unsigned TIMEOUT = 4095
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   req_data,
    input  logic [NREQ*NSLV-1:0] req_slave,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      ack,
    output logic [NREQ-1:0]      err,
    output logic                 busy,
    output logic                 spi_start,
    output logic [DW-1:0]        spi_din,
    output logic [NSLV-1:0]      spi_slave,
    input  logic                 spi_done
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    arb_state_e     state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d, widx_q, widx_d;
    logic [DW-1:0]   din_q, din_d;
    logic [NSLV-1:0] slv_q, slv_d;
    logic [NREQ-1:0] gnt_q, gnt_d, ack_q, ack_d, err_q, err_d;
    logic            start_q, start_d, busy_q, busy_d;
    logic [TW-1:0]   timer_q, timer_d;

    logic [NREQ-1:0] win;
    logic [IW-1:0]   win_idx, nxt_win, nxt_cur;
    logic            any, slv_ok;
    logic [NSLV-1:0] slv_pick;
    logic [NREQ-1:0] cur_oh;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .win     (win),
        .win_idx (win_idx),
        .any     (any)
    );

    assign slv_pick = req_slave[win_idx*NSLV +: NSLV];
    assign slv_ok   = (slv_pick != '0) && ((slv_pick & (slv_pick - NSLV'(1))) == '0);
    assign nxt_win  = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + IW'(1);
    assign nxt_cur  = (widx_q == IW'(NREQ - 1)) ? '0 : widx_q + IW'(1);
    assign cur_oh   = NREQ'(1) << widx_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        widx_d  = widx_q;
        din_d   = din_q;
        slv_d   = slv_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        err_d   = '0;
        start_d = start_q;
        timer_d = timer_q;
        unique case (state_q)
            // GAP arbitrates like IDLE so back-to-back transfers see start low
            // only for the DONE and GAP cycles.
            ST_IDLE, ST_GAP: begin
                state_d = ST_IDLE;
                start_d = 1'b0;
                gnt_d   = '0;
                if (any) begin
                    widx_d = win_idx;
                    din_d  = req_data[win_idx*DW +: DW];
                    slv_d  = slv_pick;
                    if (slv_ok) begin
                        state_d = ST_XFER;
                        gnt_d   = win;
                        start_d = 1'b1;
                        timer_d = '0;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = win;
                        ptr_d   = nxt_win;
                    end
                end
            end
            ST_XFER: begin
                if (spi_done) begin
                    state_d = ST_DONE;
                    ack_d   = cur_oh;
                    gnt_d   = '0;
                    start_d = 1'b0;
                    ptr_d   = nxt_cur;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    state_d = ST_ERR;
                    err_d   = cur_oh;
                    gnt_d   = '0;
                    start_d = 1'b0;
                    ptr_d   = nxt_cur;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_DONE, ST_ERR: state_d = ST_GAP;
            default:         state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            widx_q  <= '0;
            din_q   <= '0;
            slv_q   <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            err_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            widx_q  <= widx_d;
            din_q   <= din_d;
            slv_q   <= slv_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            timer_q <= timer_d;
        end
    end

    assign gnt       = gnt_q;
    assign ack       = ack_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign spi_start = start_q;
    assign spi_din   = din_q;
    assign spi_slave = slv_q;

endmodule

// File: tb/tb_spi_rr_arbiter.sv
// Directed bench for spi_rr_arbiter; the SPI master's done signal is driven
// directly so transfer length and timeout behaviour are exactly controlled.
module tb_spi_rr_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned DW   = 12;
    localparam int unsigned NSLV = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ*NSLV-1:0] req_slave;
    logic [NREQ-1:0]      gnt, ack, err;
    logic                 busy, spi_start, spi_done;
    logic [DW-1:0]        spi_din;
    logic [NSLV-1:0]      spi_slave;

    int n_checks = 0;
    int n_errors = 0;

    spi_rr_arbiter #(.NREQ(NREQ), .DW(DW), .NSLV(NSLV), .TIMEOUT(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_data  (req_data),
        .req_slave (req_slave),
        .gnt       (gnt),
        .ack       (ack),
        .err       (err),
        .busy      (busy),
        .spi_start (spi_start),
        .spi_din   (spi_din),
        .spi_slave (spi_slave),
        .spi_done  (spi_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".gnt"},   32'(gnt), 0);
        check({tag, ".start"}, 32'(spi_start), 0);
        check({tag, ".busy"},  32'(busy), 0);
        check({tag, ".ack"},   32'(ack), 0);
        check({tag, ".err"},   32'(err), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int order [5];
        order = '{0, 1, 2, 3, 0};
        rst_n     = 1'b0;
        req       = '0;
        req_data  = '0;
        req_slave = '0;
        spi_done  = 1'b0;
        do_reset();
        check_idle("reset");

        // 1: single requester
        req_data[0*DW +: DW]     = 12'hA5C;
        req_slave[0*NSLV +: NSLV] = 4'b0001;
        req = 4'b0001;
        step();
        check("t1.gnt", 32'(gnt), 32'h1);
        check("t1.start", 32'(spi_start), 1);
        check("t1.din", 32'(spi_din), 32'hA5C);
        check("t1.slave", 32'(spi_slave), 32'h1);
        check("t1.busy", 32'(busy), 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t1.hold_start", 32'(spi_start), 1);
            check("t1.hold_din", 32'(spi_din), 32'hA5C);
            check("t1.no_ack", 32'(ack), 0);
        end
        spi_done = 1'b1;
        step();
        spi_done = 1'b0;
        check("t1.ack", 32'(ack), 32'h1);
        check("t1.start_low", 32'(spi_start), 0);
        check("t1.gnt_low", 32'(gnt), 0);
        req = '0;
        step();
        check("t1.gap_ack", 32'(ack), 0);
        check("t1.gap_busy", 32'(busy), 1);
        check("t1.gap_start", 32'(spi_start), 0);
        step();
        check_idle("t1.idle");

        // 2: all requesting, fairness and 2-cycle start-low gap
        do_reset();
        for (int i = 0; i < 4; i++) begin
            req_data[i*DW +: DW]       = 12'(12'h300 + 12'(i * 17));
            req_slave[i*NSLV +: NSLV] = 4'(1 << i);
        end
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            check("t2.gnt", 32'(gnt), 32'(1 << order[k]));
            check("t2.start", 32'(spi_start), 1);
            check("t2.din", 32'(spi_din), 32'h300 + 32'(order[k] * 17));
            check("t2.slave", 32'(spi_slave), 32'(1 << order[k]));
            spi_done = 1'b1;
            step();
            spi_done = 1'b0;
            check("t2.ack", 32'(ack), 32'(1 << order[k]));
            check("t2.done_start", 32'(spi_start), 0);
            if (k == 4) req = '0;
            step();
            check("t2.gap_start", 32'(spi_start), 0);
            check("t2.gap_ack", 32'(ack), 0);
        end
        step();
        check_idle("t2.idle");

        // 3: bad slave selects on requester 2 (pointer is 1 here)
        req_slave[2*NSLV +: NSLV] = 4'b0000;
        req = 4'b0100;
        for (int k = 0; k < 2; k++) begin
            step();
            check("t3.err", 32'(err), 32'h4);
            check("t3.start", 32'(spi_start), 0);
            check("t3.ack", 32'(ack), 0);
            req = '0;
            step();
            check("t3.gap_err", 32'(err), 0);
            check("t3.gap_start", 32'(spi_start), 0);
            step();
            check_idle("t3.idle");
            req_slave[2*NSLV +: NSLV] = 4'b0110;
            req = 4'b0100;
        end
        req = '0;
        req_slave[2*NSLV +: NSLV] = 4'b0100;
        req = 4'b1111;
        step();
        check("t3.ptr_next", 32'(gnt), 32'h8);
        spi_done = 1'b1;
        req = '0;
        step();
        spi_done = 1'b0;
        check("t3.ack3", 32'(ack), 32'h8);
        step();
        step();

        // 4: timeout (pointer is 0 here)
        req = 4'b0001;
        step();
        check("t4.start_rise", 32'(spi_start), 1);
        for (int k = 0; k < 15; k++) begin
            step();
            check("t4.start_hold", 32'(spi_start), 1);
            check("t4.no_err", 32'(err), 0);
        end
        step();
        check("t4.timeout_err", 32'(err), 32'h1);
        check("t4.timeout_start", 32'(spi_start), 0);
        check("t4.timeout_ack", 32'(ack), 0);
        req = '0;
        step();
        step();
        req = 4'b0010;
        step();
        check("t4r.start_rise", 32'(spi_start), 1);
        for (int k = 0; k < 15; k++) begin
            step();
            check("t4r.start_hold", 32'(spi_start), 1);
        end
        spi_done = 1'b1;
        step();
        spi_done = 1'b0;
        check("t4r.ack", 32'(ack), 32'h2);
        check("t4r.err", 32'(err), 0);
        req = '0;
        step();
        step();

        // 5: reset mid-transfer (pointer is 2 here)
        req = 4'b1000;
        step();
        check("t5.gnt", 32'(gnt), 32'h8);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check_idle("t5.reset");
        req = 4'b1010;
        step();
        check("t5.first_after_reset", 32'(gnt), 32'h2);
        check("t5.din", 32'(spi_din), 32'h311);
        spi_done = 1'b1;
        req = '0;
        step();
        check("t5.ack", 32'(ack), 32'h2);

        // 6: done ignored in GAP and IDLE
        step();
        check("t6.gap_ack", 32'(ack), 0);
        check("t6.gap_busy", 32'(busy), 1);
        step();
        check_idle("t6.idle1");
        step();
        check_idle("t6.idle2");
        spi_done = 1'b0;
        step();
        check_idle("t6.idle3");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
